// File: rtl/effect_echo.sv
// effect_echo: single-tap echo over a circular sample buffer, with wet/dry mix
// and optional feedback.
// Define ECHO_FEEDBACK_EN to enable feedback (repeating decaying echo); without
// it only the dry input is written back to the buffer (single echo).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid          one-cycle new-sample strobe
//   i_enable         1 = echo on, 0 = bypass (buffer still records dry input)
//   i_level          delay select, D = (level+1) * 2^(ADDR_W-3)
//   i_data           signed audio in
//   o_data, o_valid  registered audio out and one-cycle output strobe
module effect_echo #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WET    = 128,
  parameter int unsigned FB     = 96
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned SEG_SH = ADDR_W - 3;

  localparam logic signed [ACC_W-1:0] WET_S   = ACC_W'(WET);
  localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_MIX,
    ST_WRITE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]        clr_cnt, clr_cnt_nxt;
  logic [ADDR_W-1:0]        wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]        rd_addr, rd_addr_nxt;
  logic signed [DATA_W-1:0] x_q, x_nxt;
  logic                     en_q, en_nxt;
  logic signed [DATA_W-1:0] out_q, out_nxt;
  logic signed [DATA_W-1:0] wb_q, wb_nxt;
  logic signed [DATA_W-1:0] o_data_nxt;
  logic                     o_valid_nxt;

  logic                     clr_last_c;
  logic [ADDR_W:0]          dly_len_c;
  logic                     mem_we_c;
  logic                     mem_re_c;
  logic [ADDR_W-1:0]        mem_addr_c;
  logic [DATA_W-1:0]        mem_wdata_c;
  logic signed [DATA_W-1:0] rd_data;

  logic signed [ACC_W-1:0]  dly_ext_c;
  logic signed [ACC_W-1:0]  x_ext_c;
  logic signed [ACC_W-1:0]  mix_out_c;
  logic signed [DATA_W-1:0] out_sat_c;
  logic signed [DATA_W-1:0] wb_sat_c;

  // Clamp a 32-bit mix result to the 16-bit sample range
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return DATA_W'(SAT_MAX);
    else if (v < SAT_MIN) return DATA_W'(SAT_MIN);
    else                  return v[DATA_W-1:0];
  endfunction

  assign clr_last_c = (clr_cnt == ADDR_W'(DEPTH - 1));

  // Level 7 gives D = depth, which truncates to 0: read address = wr_ptr (oldest sample)
  assign dly_len_c = ((ADDR_W+1)'(i_level) + (ADDR_W+1)'(1)) << SEG_SH;

  // Mix datapath, valid in MIX
  assign dly_ext_c = {{(ACC_W-DATA_W){rd_data[DATA_W-1]}}, rd_data};
  assign x_ext_c   = {{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q};
  assign mix_out_c = x_ext_c + ((dly_ext_c * WET_S) >>> 8);
  assign out_sat_c = sat16(mix_out_c);

`ifdef ECHO_FEEDBACK_EN
  localparam logic signed [ACC_W-1:0] FB_S = ACC_W'(FB);
  logic signed [ACC_W-1:0] mix_wb_c;
  assign mix_wb_c = x_ext_c + ((dly_ext_c * FB_S) >>> 8);
  assign wb_sat_c = sat16(mix_wb_c);
`else
  logic unused_fb;
  assign unused_fb = ^(ACC_W'(FB));
  assign wb_sat_c  = x_q;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_CLEAR;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_last_c) state_nxt = ST_IDLE;
      ST_IDLE:  if (i_valid)    state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_MIX;
      ST_MIX:   state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Output / datapath next values and buffer port control
  always_comb begin
    clr_cnt_nxt = clr_cnt;
    wr_ptr_nxt  = wr_ptr;
    rd_addr_nxt = rd_addr;
    x_nxt       = x_q;
    en_nxt      = en_q;
    out_nxt     = out_q;
    wb_nxt      = wb_q;
    o_data_nxt  = o_data;
    o_valid_nxt = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = wr_ptr;
    mem_wdata_c = '0;
    case (state)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_cnt;
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        if (clr_last_c) wr_ptr_nxt = '0;
        // Samples arriving while the buffer is being zeroed pass straight through
        if (i_valid) begin
          o_valid_nxt = 1'b1;
          o_data_nxt  = i_data;
        end
      end
      ST_IDLE: begin
        if (i_valid) begin
          x_nxt       = i_data;
          en_nxt      = i_enable;
          rd_addr_nxt = wr_ptr - dly_len_c[ADDR_W-1:0];
        end
      end
      ST_READ: begin
        mem_re_c   = 1'b1;
        mem_addr_c = rd_addr;
      end
      ST_MIX: begin
        out_nxt = out_sat_c;
        wb_nxt  = wb_sat_c;
      end
      ST_WRITE: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = wr_ptr;
        mem_wdata_c = en_q ? wb_q : x_q;
        o_data_nxt  = en_q ? out_q : x_q;
        o_valid_nxt = 1'b1;
        wr_ptr_nxt  = wr_ptr + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt <= '0;
      wr_ptr  <= '0;
      rd_addr <= '0;
      x_q     <= '0;
      en_q    <= 1'b0;
      out_q   <= '0;
      wb_q    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      clr_cnt <= clr_cnt_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_addr <= rd_addr_nxt;
      x_q     <= x_nxt;
      en_q    <= en_nxt;
      out_q   <= out_nxt;
      wb_q    <= wb_nxt;
      o_data  <= o_data_nxt;
      o_valid <= o_valid_nxt;
    end
  end

  // Single-port sample buffer; contents are zeroed by CLEAR, not by reset
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (mem_we_c)      mem[mem_addr_c] <= mem_wdata_c;
    else if (mem_re_c) rd_data <= mem[mem_addr_c];
  end

endmodule

// File: tb/tb_effect_echo.sv
// Directed testbench for effect_echo at ADDR_W=6, WET=128, FB=96.
// Feedback-dependent expectations follow ECHO_FEEDBACK_EN.
module tb_effect_echo;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_enable = 1'b0;
  logic [2:0]         i_level = 3'd0;
  logic signed [15:0] i_data = '0;
  logic signed [15:0] o_data;
  logic               o_valid;

  int total = 0;
  int bad   = 0;

`ifdef ECHO_FEEDBACK_EN
  localparam int E16 = 3000;
  localparam int E24 = 1125;
`else
  localparam int E16 = 0;
  localparam int E24 = 0;
`endif

  effect_echo #(.ADDR_W(6), .WET(128), .FB(96)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_enable (i_enable),
    .i_level  (i_level),
    .i_data   (i_data),
    .o_data   (o_data),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  // Drive one strobe and watch 7 negedges; lat = negedge index of first o_valid
  task automatic run_sample(input logic signed [15:0] d, input logic en, input logic [2:0] lvl,
                            output logic signed [15:0] got, output int lat, output int pulses);
    got = '0; lat = 0; pulses = 0;
    @(negedge clk);
    i_valid = 1'b1; i_data = d; i_enable = en; i_level = lvl;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_valid = 1'b0; i_data = 16'sh5a5a; i_enable = ~en; i_level = ~lvl;
      end
      if (o_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = k; got = o_data; end
      end
    end
  endtask

  // Full reset followed by enough cycles for the 64-entry CLEAR to finish
  task automatic reset_and_clear();
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    total++;
    if (o_data !== 16'sd0) begin bad++; $display("FAIL reset_o_data got=%0d want=0", o_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clear_dry();
    logic signed [15:0] got, exp;
    int lat, pulses;
    // Passthrough while CLEAR is running
    for (int i = 0; i < 2; i++) begin
      exp = 16'(-1200 + i * 777);
      run_sample(exp, 1'b1, 3'd0, got, lat, pulses);
      total++;
      if (got !== exp || lat != 1 || pulses != 1) begin
        bad++; $display("FAIL clear_pass%0d got=%0d lat=%0d n=%0d want=%0d lat=1 n=1", i, got, lat, pulses, exp);
      end
    end
    repeat (60) @(negedge clk);
    // Zeroed buffer: first 8 outputs are dry
    for (int i = 0; i < 8; i++) begin
      exp = 16'((i + 1) * 100);
      run_sample(exp, 1'b1, 3'd0, got, lat, pulses);
      total++;
      if (got !== exp || lat != 4 || pulses != 1) begin
        bad++; $display("FAIL post_clear_dry%0d got=%0d lat=%0d n=%0d want=%0d lat=4 n=1", i, got, lat, pulses, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp = 16'((i + 1) * 50);
      run_sample(16'sd0, 1'b1, 3'd0, got, lat, pulses);
      total++;
      if (got !== exp) begin bad++; $display("FAIL post_clear_echo%0d got=%0d want=%0d", i, got, exp); end
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] got, exp;
    int lat, pulses;
    reset_and_clear();
    for (int i = 0; i <= 24; i++) begin
      case (i)
        0:       exp = 16'sd16000;
        8:       exp = 16'sd8000;
        16:      exp = 16'(E16);
        24:      exp = 16'(E24);
        default: exp = 16'sd0;
      endcase
      run_sample((i == 0) ? 16'sd16000 : 16'sd0, 1'b1, 3'd0, got, lat, pulses);
      total++;
      if (got !== exp || lat != 4 || pulses != 1) begin
        bad++; $display("FAIL impulse_s%0d got=%0d lat=%0d n=%0d want=%0d lat=4 n=1", i, got, lat, pulses, exp);
      end
    end
  endtask

  task automatic test_level7();
    logic signed [15:0] got, exp;
    int lat, pulses;
    int errs;
    reset_and_clear();
    errs = 0;
    for (int i = 0; i <= 64; i++) begin
      exp = (i == 0) ? 16'sd16000 : (i == 64) ? 16'sd8000 : 16'sd0;
      run_sample((i == 0) ? 16'sd16000 : 16'sd0, 1'b1, 3'd7, got, lat, pulses);
      if (i == 0 || i == 63 || i == 64) begin
        total++;
        if (got !== exp) begin bad++; $display("FAIL level7_s%0d got=%0d want=%0d", i, got, exp); end
      end else if (got !== exp) begin
        errs++;
      end
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL level7_silence got=%0d nonzero want=0", errs); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] got, exp, din;
    int lat, pulses;
    for (int s = 0; s < 2; s++) begin
      reset_and_clear();
      din = (s == 0) ? 16'sd30000 : -16'sd30000;
      for (int i = 0; i < 12; i++) begin
        exp = (i < 8) ? din : ((s == 0) ? 16'sd32767 : -16'sd32768);
        run_sample(din, 1'b1, 3'd0, got, lat, pulses);
        if (i == 0 || i == 7 || i == 8 || i == 11) begin
          total++;
          if (got !== exp) begin bad++; $display("FAIL sat%0d_s%0d got=%0d want=%0d", s, i, got, exp); end
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic signed [15:0] got, exp;
    int lat, pulses;
    reset_and_clear();
    for (int i = 0; i < 8; i++) begin
      exp = (i == 0) ? 16'sd16000 : 16'(i * 3 - 10);
      run_sample(exp, 1'b0, 3'd0, got, lat, pulses);
      if (i == 0 || i == 5) begin
        total++;
        if (got !== exp || lat != 4 || pulses != 1) begin
          bad++; $display("FAIL bypass_s%0d got=%0d lat=%0d n=%0d want=%0d lat=4 n=1", i, got, lat, pulses, exp);
        end
      end
    end
    // Enabling now must find the dry impulse recorded during bypass
    run_sample(16'sd0, 1'b1, 3'd0, got, lat, pulses);
    total++;
    if (got !== 16'sd8000) begin bad++; $display("FAIL bypass_history got=%0d want=8000", got); end
  endtask

  task automatic test_overlap();
    logic signed [15:0] got;
    int lat, pulses;
    reset_and_clear();
    lat = 0; pulses = 0; got = '0;
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'sd1000; i_enable = 1'b0; i_level = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) begin i_valid = 1'b1; i_data = 16'sd2222; end
      else        begin i_valid = 1'b0; i_data = 16'sd0; end
      if (o_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = k; got = o_data; end
      end
    end
    total++;
    if (pulses != 1 || lat != 4 || got !== 16'sd1000) begin
      bad++; $display("FAIL overlap got=%0d lat=%0d n=%0d want=1000 lat=4 n=1", got, lat, pulses);
    end
    run_sample(16'sd333, 1'b0, 3'd0, got, lat, pulses);
    total++;
    if (got !== 16'sd333 || lat != 4 || pulses != 1) begin
      bad++; $display("FAIL overlap_after got=%0d lat=%0d n=%0d want=333 lat=4 n=1", got, lat, pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] got;
    int lat, pulses;
    reset_and_clear();
    run_sample(16'sd1234, 1'b0, 3'd0, got, lat, pulses);
    repeat (3) @(negedge clk);
    total++;
    if (o_data !== 16'sd1234 || o_valid !== 1'b0) begin
      bad++; $display("FAIL hold got=%0d v=%b want=1234 v=0", o_data, o_valid);
    end
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'sd777; i_enable = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);   // state is MIX here
    rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_data !== 16'sd0) begin
      bad++; $display("FAIL reset_mid got=%0d v=%b want=0 v=0", o_data, o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL reset_mid_discard got=%0d pulses want=0", pulses); end
    run_sample(-16'sd4321, 1'b1, 3'd3, got, lat, pulses);
    total++;
    if (got !== -16'sd4321 || lat != 1 || pulses != 1) begin
      bad++; $display("FAIL reset_mid_clear_pass got=%0d lat=%0d n=%0d want=-4321 lat=1 n=1", got, lat, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_clear_dry();
    test_impulse();
    test_level7();
    test_saturation();
    test_bypass();
    test_overlap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
